lsu_mmio: RTL and testbench

Parametrised load-store unit sitting between the processor's execute stage and the data memory / memory-mapped I/O. It decodes each request into one of three regions: byte-enabled data memory, N_OUT writable output channels (LEDs, 7-segment, LCD), or N_IN synchronised input channels (switches, keys). It handles signed and unsigned byte/half/word access with misalignment and unmapped-address error reporting. Loads complete with a fixed one-cycle registered response.

---
 rtl/lsu_mmio_pkg.sv | 59 +++++
 rtl/lsu_mmio_if.sv | 21 ++
 rtl/lsu_dmem_be.sv | 24 ++
 rtl/lsu_mmio.sv | 137 +++++++++++++
 tb/tb_lsu_mmio.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mmio_pkg.sv
// Shared types, address map constants and lane helpers for the load-store unit.
package lsu_mmio_pkg;

   typedef enum logic [2:0] {
      MODE_B  = 3'b000,
      MODE_H  = 3'b001,
      MODE_W  = 3'b010,
      MODE_BU = 3'b100,
      MODE_HU = 3'b101
   } mode_e;

   typedef enum logic [1:0] {
      REG_DMEM,
      REG_OUT,
      REG_IN,
      REG_NONE
   } region_e;

   localparam logic [31:0] DMEM_BASE   = 32'h0000_2000;
   localparam logic [31:0] OUT_BASE    = 32'h0000_7000;
   localparam logic [31:0] IN_BASE     = 32'h0000_7800;
   localparam logic [31:0] SLOT_STRIDE = 32'h0000_0010;

   // Everything the response cycle needs to rebuild load data.
   typedef struct packed {
      logic       vld;
      logic       err;
      logic       ld;
      region_e    region;
      logic [3:0] idx;
      logic [2:0] mode;
      logic [1:0] off;
   } rsp_t;

   // Byte lanes touched by an access of the given size at the given byte offset.
   function automatic logic [3:0] be_gen(input logic [2:0] mode, input logic [1:0] off);
      case (mode)
         MODE_B, MODE_BU: be_gen = 4'b0001 << off;
         MODE_H, MODE_HU: be_gen = 4'b0011 << off;
         MODE_W:          be_gen = 4'b1111;
         default:         be_gen = 4'b0000;
      endcase
   endfunction

   // Right-align the addressed bytes of a word and extend to 32 bits.
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] mode,
                                            input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (mode)
         MODE_B:  load_ext = {{24{sh[7]}}, sh[7:0]};
         MODE_BU: load_ext = {24'h0, sh[7:0]};
         MODE_H:  load_ext = {{16{sh[15]}}, sh[15:0]};
         MODE_HU: load_ext = {16'h0, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mmio_if.sv
// Request/response bus between the execute stage and the load-store unit.
interface lsu_mmio_if;
   logic        req_i;
   logic        we_i;
   logic [2:0]  mode_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, we_i, mode_i, addr_i, wdata_i,
      input  rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, mode_i, addr_i, wdata_i,
      output rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/lsu_dmem_be.sv
// Single-port data RAM with byte-lane write enables and a registered read port.
module lsu_dmem_be #(
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];

   // Read-first port: lane writes and the read register share one edge.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i && be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_o <= mem[addr_i];
   end

endmodule

// File: rtl/lsu_mmio.sv
// Load-store unit: decodes requests into DMEM / output channels / input channels,
// performs lane-enabled stores and returns extended load data one cycle later.
module lsu_mmio
   import lsu_mmio_pkg::*;
#(
   parameter int DMEM_WORDS = 2048,
   parameter int N_OUT      = 4,
   parameter int N_IN       = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   lsu_mmio_if.slave            bus,
   input  logic [32*N_IN-1:0]   in_i,
   output logic [32*N_OUT-1:0]  out_o
);

   localparam int          AW        = $clog2(DMEM_WORDS);
   localparam logic [31:0] DMEM_SIZE = 32'(4 * DMEM_WORDS);
   localparam logic [31:0] OUT_SPAN  = 32'(N_OUT) * SLOT_STRIDE;
   localparam logic [31:0] IN_SPAN   = 32'(N_IN) * SLOT_STRIDE;

   logic [31:0]              doff, ooff, ioff;
   region_e                  region;
   logic [3:0]               idx;
   logic                     mode_ok, align_ok, err, wr_ok;
   logic [3:0]               be;
   logic [31:0]              wdata_lane;
   logic [31:0]              ram_rdata;
   logic [N_OUT-1:0][31:0]   out_q;
   logic [N_IN-1:0][31:0]    sync1_q, sync2_q;
   rsp_t                     rsp_q;
   logic [31:0]              rsp_word;

   // Region decode, error classification and store lane formatting.
   always_comb begin
      // Offsets wrap below the base, so one unsigned compare bounds each window.
      doff   = bus.addr_i - DMEM_BASE;
      ooff   = bus.addr_i - OUT_BASE;
      ioff   = bus.addr_i - IN_BASE;
      region = REG_NONE;
      idx    = '0;
      if (doff < DMEM_SIZE) begin
         region = REG_DMEM;
      end else if (ooff < OUT_SPAN && ooff[3:2] == 2'b00) begin
         region = REG_OUT;
         idx    = ooff[7:4];
      end else if (ioff < IN_SPAN && ioff[3:2] == 2'b00) begin
         region = REG_IN;
         idx    = ioff[7:4];
      end

      mode_ok  = 1'b1;
      align_ok = 1'b1;
      case (bus.mode_i)
         MODE_B, MODE_BU: ;
         MODE_H, MODE_HU: align_ok = ~bus.addr_i[0];
         MODE_W:          align_ok = (bus.addr_i[1:0] == 2'b00);
         default:         mode_ok  = 1'b0;
      endcase

      err   = !mode_ok || !align_ok || region == REG_NONE || (bus.we_i && region == REG_IN);
      wr_ok = bus.req_i && bus.we_i && !err;
      be    = be_gen(bus.mode_i, bus.addr_i[1:0]);

      case (bus.mode_i)
         MODE_B, MODE_BU: wdata_lane = {4{bus.wdata_i[7:0]}};
         MODE_H, MODE_HU: wdata_lane = {2{bus.wdata_i[15:0]}};
         default:         wdata_lane = bus.wdata_i;
      endcase
   end

   lsu_dmem_be #(.DEPTH(DMEM_WORDS), .AW(AW)) u_dmem (
      .clk_i   (clk_i),
      .we_i    (wr_ok && region == REG_DMEM),
      .be_i    (be),
      .addr_i  (doff[AW+1:2]),
      .wdata_i (wdata_lane),
      .rdata_o (ram_rdata)
   );

   // Output channel registers, written lane by lane; reset wins over a same-edge store.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q <= '0;
      end else if (wr_ok && region == REG_OUT) begin
         for (int k = 0; k < N_OUT; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (idx == 4'(k) && be[b]) out_q[k][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
         end
      end
   end

   assign out_o = out_q;

   // Two-flop synchroniser on every input channel bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_i;
         sync2_q <= sync1_q;
      end
   end

   // Response register: remembers what the load needs; reset drops a pending response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_q <= '0;
      end else begin
         rsp_q.vld    <= bus.req_i;
         rsp_q.err    <= bus.req_i && err;
         rsp_q.ld     <= bus.req_i && !bus.we_i && !err;
         rsp_q.region <= region;
         rsp_q.idx    <= idx;
         rsp_q.mode   <= bus.mode_i;
         rsp_q.off    <= bus.addr_i[1:0];
      end
   end

   // Pick the source word in the response cycle; MMIO is read live so the
   // synchroniser output of this cycle is what a load returns.
   always_comb begin
      rsp_word = ram_rdata;
      if (rsp_q.region == REG_OUT) begin
         for (int k = 0; k < N_OUT; k++) if (rsp_q.idx == 4'(k)) rsp_word = out_q[k];
      end else if (rsp_q.region == REG_IN) begin
         for (int j = 0; j < N_IN; j++) if (rsp_q.idx == 4'(j)) rsp_word = sync2_q[j];
      end
   end

   assign bus.rvalid_o = rsp_q.vld;
   assign bus.err_o    = rsp_q.vld && rsp_q.err;
   assign bus.rdata_o  = (rsp_q.vld && rsp_q.ld) ? load_ext(rsp_word, rsp_q.mode, rsp_q.off) : 32'h0;

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: directed scenarios plus randomized traffic
// checked against a byte-addressed reference model.
module tb_lsu_mmio;

   localparam int DW = 2048;
   localparam int NO = 4;
   localparam int NI = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [32*NI-1:0] in_i;
   logic [32*NO-1:0] out_o;

   lsu_mmio_if bus();

   lsu_mmio #(.DMEM_WORDS(DW), .N_OUT(NO), .N_IN(NI)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus),
      .in_i  (in_i),
      .out_o (out_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: memory as individual bytes, channels as whole words.
   logic [7:0]  mem_m [int];
   logic [31:0] out_m [NO];
   logic [31:0] in_m  [NI];

   logic        obs_rv, obs_er, exp_e;
   logic [31:0] obs_rd, exp_rd;

   function automatic logic [32*NO-1:0] out_exp();
      logic [32*NO-1:0] v;
      for (int k = 0; k < NO; k++) v[32*k +: 32] = out_m[k];
      return v;
   endfunction

   // Architectural behaviour of one request: byte-by-byte little-endian access.
   task automatic model_xact(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic e, output logic [31:0] rd);
      int size, ko, ki, l;
      bit sgn, is_d, is_o, is_i;
      logic [31:0] a;
      logic [7:0]  byt;
      size = 0; sgn = 0;
      case (mode)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: size = 4;
         3'd4: size = 1;
         3'd5: size = 2;
         default: size = 0;
      endcase
      is_d = addr >= 32'h2000 && addr < 32'h2000 + 4*DW;
      is_o = addr >= 32'h7000 && addr < 32'h7000 + 16*NO && addr[3:2] == 2'b00;
      is_i = addr >= 32'h7800 && addr < 32'h7800 + 16*NI && addr[3:2] == 2'b00;
      rd = 0;
      if (size == 0) e = 1;
      else e = (addr % size != 0) || !(is_d || is_o || is_i) || (we && is_i);
      if (!e) begin
         for (int b = 0; b < size; b++) begin
            a  = addr + b;
            l  = int'(a[1:0]);
            ko = int'((a - 32'h7000) >> 4);
            ki = int'((a - 32'h7800) >> 4);
            if (we) begin
               if (is_d) mem_m[int'(a)] = wdata[8*b +: 8];
               else      out_m[ko][8*l +: 8] = wdata[8*b +: 8];
            end else begin
               if (is_d)      byt = mem_m[int'(a)];
               else if (is_o) byt = out_m[ko][8*l +: 8];
               else           byt = in_m[ki][8*l +: 8];
               rd[8*b +: 8] = byt;
            end
         end
         if (!we && sgn && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      end
   endtask

   // One request in cycle t; observations are taken in cycle t+1.
   task automatic xact(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata);
      bus.req_i = 1'b1; bus.we_i = we; bus.mode_i = mode; bus.addr_i = addr; bus.wdata_i = wdata;
      model_xact(we, mode, addr, wdata, exp_e, exp_rd);
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      obs_rv = bus.rvalid_o; obs_er = bus.err_o; obs_rd = bus.rdata_o;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== 34'h0) begin
         miscompares++;
         $display("FAIL reset_rsp got %h want 0", {bus.rvalid_o, bus.err_o, bus.rdata_o});
      end
      vectors++;
      if (out_o !== '0) begin miscompares++; $display("FAIL reset_out got %h want 0", out_o); end
      rst = 1'b0;
      xact(0, 3'd2, 32'h7000, 0);
      vectors++;
      if ({obs_rv, obs_er, obs_rd} !== {1'b1, 1'b0, 32'h0}) begin
         miscompares++; $display("FAIL first_load got %h want %h", {obs_rv, obs_er, obs_rd}, {1'b1, 1'b0, 32'h0});
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rvalid_one_cycle got %b want 0", bus.rvalid_o); end
   endtask

   task automatic test_dmem_ext();
      logic [31:0] want [5];
      logic [2:0]  md   [5];
      logic [31:0] ad   [5];
      want = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899, 32'h8899_AABB};
      md   = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      ad   = '{32'h2005, 32'h2005, 32'h2006, 32'h2006, 32'h2004};
      xact(1, 3'd2, 32'h2004, 32'h8899_AABB);
      vectors++;
      if ({obs_rv, obs_er, obs_rd} !== {1'b1, 1'b0, 32'h0}) begin
         miscompares++; $display("FAIL sw_2004 got %h want %h", {obs_rv, obs_er, obs_rd}, {1'b1, 1'b0, 32'h0});
      end
      for (int i = 0; i < 5; i++) begin
         xact(0, md[i], ad[i], 0);
         vectors++;
         if ({obs_rv, obs_er, obs_rd} !== {1'b1, 1'b0, want[i]}) begin
            miscompares++;
            $display("FAIL ext_load%0d got %h want %h", i, {obs_rv, obs_er, obs_rd}, {1'b1, 1'b0, want[i]});
         end
      end
   endtask

   task automatic test_out_store();
      xact(1, 3'd2, 32'h7010, 32'h1122_3344);
      xact(1, 3'd0, 32'h7011, 32'hFFFF_FF5A);
      vectors++;
      if (out_o[63:32] !== 32'h1122_5A44 || out_o[31:0] !== 32'h0) begin
         miscompares++; $display("FAIL sb_out1 got %h want 11225a44", out_o[63:32]);
      end
      xact(0, 3'd2, 32'h7010, 0);
      vectors++;
      if (obs_rd !== 32'h1122_5A44 || obs_er !== 1'b0) begin
         miscompares++; $display("FAIL lw_out1 got %h want 11225a44", obs_rd);
      end
      xact(1, 3'd1, 32'h7032, 32'h1234_BEEF);
      vectors++;
      if (out_o[127:96] !== 32'hBEEF_0000) begin
         miscompares++; $display("FAIL sh_out3 got %h want beef0000", out_o[127:96]);
      end
   endtask

   task automatic test_errors();
      logic [31:0] ea [8];
      logic [2:0]  em [8];
      logic        ew [8];
      ea = '{32'h2002, 32'h2001, 32'h7800, 32'h5000, 32'h2000, 32'h7004, 32'h4000, 32'h7820};
      em = '{3'd2,     3'd1,     3'd2,     3'd2,     3'd3,     3'd2,     3'd2,     3'd2};
      ew = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0};
      xact(1, 3'd2, 32'h2000, 32'h0102_0304);
      for (int i = 0; i < 8; i++) begin
         xact(ew[i], em[i], ea[i], 32'hCAFE_BABE);
         vectors++;
         if ({obs_rv, obs_er, obs_rd} !== {1'b1, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL err_case%0d got %h want %h", i, {obs_rv, obs_er, obs_rd}, {1'b1, 1'b1, 32'h0});
         end
      end
      xact(0, 3'd2, 32'h2000, 0);
      vectors++;
      if (obs_rd !== 32'h0102_0304) begin miscompares++; $display("FAIL no_write_2000 got %h want 01020304", obs_rd); end
      xact(0, 3'd2, 32'h2004, 0);
      vectors++;
      if (obs_rd !== 32'h8899_AABB) begin miscompares++; $display("FAIL no_write_2004 got %h want 8899aabb", obs_rd); end
      xact(1, 3'd2, 32'h3FFC, 32'h55AA_55AA);
      xact(0, 3'd2, 32'h3FFC, 0);
      vectors++;
      if ({obs_er, obs_rd} !== {1'b0, 32'h55AA_55AA}) begin
         miscompares++; $display("FAIL dmem_top got %h want 55aa55aa", obs_rd);
      end
   endtask

   task automatic test_input_sync();
      in_i = {32'h0, 32'h1234_5678};
      in_m[0] = 32'h1234_5678; in_m[1] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      in_i[31:0] = 32'h0000_ABCD;
      xact(0, 3'd2, 32'h7800, 0);
      vectors++;
      if (obs_rd !== 32'h1234_5678) begin miscompares++; $display("FAIL in_edge1 got %h want 12345678", obs_rd); end
      xact(0, 3'd2, 32'h7800, 0);
      vectors++;
      if (obs_rd !== 32'h0000_ABCD) begin miscompares++; $display("FAIL in_edge2 got %h want 0000abcd", obs_rd); end
      in_m[0] = 32'h0000_ABCD;
   endtask

   task automatic test_back_to_back();
      xact(1, 3'd2, 32'h2100, 32'hDEAD_BEEF);
      xact(0, 3'd2, 32'h2100, 0);
      vectors++;
      if (obs_rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL b2b_load got %h want deadbeef", obs_rd); end
      // Store in t, reset raised in t+1 together with a store to channel 0.
      xact(1, 3'd2, 32'h2104, 32'h0000_0001);
      rst = 1'b1;
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.mode_i = 3'd2; bus.addr_i = 32'h7000; bus.wdata_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      vectors++;
      if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== 34'h0 || out_o !== '0) begin
         miscompares++;
         $display("FAIL rst_mid got rsp %h out %h want 0", {bus.rvalid_o, bus.err_o, bus.rdata_o}, out_o);
      end
      for (int k = 0; k < NO; k++) out_m[k] = 32'h0;
      rst = 1'b0;
      @(posedge clk); #1;
      xact(0, 3'd2, 32'h2104, 0);
      vectors++;
      if (obs_rd !== 32'h0000_0001) begin miscompares++; $display("FAIL pre_rst_store got %h want 00000001", obs_rd); end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int          r;
      in_i = {$urandom, $urandom};
      for (int j = 0; j < NI; j++) in_m[j] = in_i[32*j +: 32];
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 64; w++) xact(1, 3'd2, 32'h2000 + 4*w, $urandom);
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5)       addr = 32'h2000 + $urandom_range(0, 255);
         else if (r < 7)  addr = 32'h7000 + 16*$urandom_range(0, NO) + $urandom_range(0, 7);
         else if (r < 9)  addr = 32'h7800 + 16*$urandom_range(0, NI) + $urandom_range(0, 5);
         else             addr = $urandom | 32'h1000_0000;
         xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom);
         vectors++;
         if ({obs_rv, obs_er, obs_rd} !== {1'b1, exp_e, exp_rd} || out_o !== out_exp()) begin
            miscompares++;
            $display("FAIL rand%0d addr %h mode %h we %b got %h want %h out %h want %h", n, bus.addr_i,
                     bus.mode_i, bus.we_i, {obs_rv, obs_er, obs_rd}, {1'b1, exp_e, exp_rd}, out_o, out_exp());
         end
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rand_idle got %b want 0", bus.rvalid_o); end
         end
      end
   endtask

   initial begin
      bus.req_i = 0; bus.we_i = 0; bus.mode_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
      in_i = '0;
      for (int k = 0; k < NO; k++) out_m[k] = 32'h0;
      for (int j = 0; j < NI; j++) in_m[j] = 32'h0;
      test_reset();
      test_dmem_ext();
      test_out_store();
      test_errors();
      test_input_sync();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired after %0d vectors", vectors);
      $fatal(1);
   end

endmodule
